// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG controller that sequences TCK/TMS/TDI from clk and captures TDO.
// Define JTAG_MASTER_TRST_EN to add an active-low TRST output pulsed at INIT and TAP-reset commands.
module jtag_master #(
  parameter int MAX_LEN = 16,
  parameter int CLK_DIV = 2,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
`ifdef JTAG_MASTER_TRST_EN
  output logic               TRST,
`endif
  input  logic               TDO
);

  localparam int IW = (LW > 3) ? LW : 3;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_TLR, S_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      idx_reg, idx_next;
  logic [CW-1:0]      cnt_reg;
  logic               op_ir_reg;
  logic [LW-1:0]      len_reg;
  logic [MAX_LEN-1:0] data_reg, cap_reg, mask_reg, mask_next;
  logic               tms_next, tdi_next;
  logic [LW-1:0]      eff_len;
  logic [IW-1:0]      last_idx;
  logic               phase_end;

  assign eff_len   = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign last_idx  = IW'(len_reg) - IW'(1);
  assign phase_end = (cnt_reg == CW'(CLK_DIV - 1));

  // Where the sequence goes at the end of the current TCK period, and the pins for the next one.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg + IW'(1);
    mask_next  = mask_reg;
    case (state_reg)
      S_INIT:  if (idx_reg == IW'(5)) begin state_next = S_IDLE; idx_next = '0; end
      S_TLR:   if (idx_reg == IW'(5)) begin state_next = S_RESP; idx_next = '0; end
      S_PRE:   if (idx_reg == (op_ir_reg ? IW'(3) : IW'(2))) begin
                 state_next = S_SHIFT;
                 idx_next   = '0;
                 mask_next  = MAX_LEN'(1);
               end
      S_SHIFT: begin
                 mask_next = mask_reg << 1;
                 if (idx_reg == last_idx) begin state_next = S_POST; idx_next = '0; end
               end
      S_POST:  if (idx_reg == IW'(1)) begin state_next = S_RESP; idx_next = '0; end
      default: ;
    endcase

    tms_next = 1'b0;
    case (state_next)
      S_INIT, S_TLR: tms_next = (idx_next < IW'(5));
      S_PRE:         tms_next = op_ir_reg ? (idx_next < IW'(2)) : (idx_next == '0);
      S_SHIFT:       tms_next = (idx_next == last_idx);
      S_POST:        tms_next = (idx_next == '0);
      default:       tms_next = 1'b0;
    endcase
    tdi_next = (state_next == S_SHIFT) && (|(data_reg & mask_next));
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= S_INIT;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      op_ir_reg <= 1'b0;
      len_reg   <= '0;
      data_reg  <= '0;
      cap_reg   <= '0;
      mask_reg  <= '0;
      TCK       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
      TRST      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cap_reg   <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            op_ir_reg <= (cmd_op == 2'd1);
            len_reg   <= eff_len;
            data_reg  <= cmd_data;
            if (cmd_op[1]) begin
              state_reg <= S_TLR;
              TMS       <= 1'b1;
`ifdef JTAG_MASTER_TRST_EN
              TRST      <= 1'b0;
`endif
            end else if (eff_len == '0) begin
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_PRE;
              TMS       <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cap_reg;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          if (state_reg == S_INIT) busy <= 1'b1;
          if (!phase_end) begin
            cnt_reg <= cnt_reg + CW'(1);
          end else begin
            cnt_reg <= '0;
            if (!TCK) begin
              // TDO was updated by the TAP on the previous falling edge.
              TCK <= 1'b1;
              if (state_reg == S_SHIFT) cap_reg <= cap_reg | ({MAX_LEN{TDO}} & mask_reg);
            end else begin
              TCK       <= 1'b0;
              state_reg <= state_next;
              idx_reg   <= idx_next;
              mask_reg  <= mask_next;
              TMS       <= tms_next;
              TDI       <= tdi_next;
`ifdef JTAG_MASTER_TRST_EN
              TRST      <= 1'b1;
`endif
              if (state_next == S_IDLE) begin
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed vector table, handshake/reset corner cases and random commands
// checked against a command-level model of TCK period counts, TMS/TDI sequences and captured TDO.
module tb_jtag_master;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_len = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        busy;
  logic        TCK, TMS, TDI, TDO;
`ifdef JTAG_MASTER_TRST_EN
  logic        TRST;
`endif

  jtag_master #(.MAX_LEN(16), .CLK_DIV(2)) dut (
    .clk(clk), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .TCK(TCK), .TMS(TMS), .TDI(TDI),
`ifdef JTAG_MASTER_TRST_EN
    .TRST(TRST),
`endif
    .TDO(TDO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pin monitor: TMS/TDI as seen by the TAP at every rising TCK.
  int rise_cnt = 0;
  int hi_total = 0;
  bit tms_all[$];
  bit tdi_all[$];
  always @(posedge TCK) begin
    tms_all.push_back(TMS);
    tdi_all.push_back(TDI);
    rise_cnt = rise_cnt + 1;
  end
  always @(posedge clk) if (TCK) hi_total = hi_total + 1;

  // TDO source: loopback of TDI, or a fixed word presented one bit per shift period.
  bit          tdo_loop = 1'b1;
  logic [15:0] tdo_pat = '0;
  int          tdo_base = 0;
  int          tdo_pre = 3;
  int          pat_idx;
  assign pat_idx = rise_cnt - tdo_base - tdo_pre;
  assign TDO = tdo_loop ? TDI : ((pat_idx >= 0 && pat_idx < 16) ? tdo_pat[pat_idx[3:0]] : 1'b1);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: JTAG TMS walk for one command, plus which periods carry shift data.
  task automatic build_exp(input logic [1:0] op, input int len, input logic [15:0] data,
                           output int n, output logic [63:0] tms, output logic [63:0] tdi,
                           output logic [63:0] tdimask);
    int eff;
    bit seq[$];
    eff = (len > 16) ? 16 : len;
    tms = '0; tdi = '0; tdimask = '0;
    if (op >= 2) begin
      for (int k = 0; k < 5; k++) seq.push_back(1'b1);
      seq.push_back(1'b0);
    end else if (eff > 0) begin
      seq.push_back(1'b1);
      if (op == 1) seq.push_back(1'b1);
      seq.push_back(1'b0);
      seq.push_back(1'b0);
      for (int i = 0; i < eff; i++) begin
        tdi[seq.size()] = data[i];
        tdimask[seq.size()] = 1'b1;
        seq.push_back(i == eff - 1);
      end
      seq.push_back(1'b1);
      seq.push_back(1'b0);
    end
    n = seq.size();
    for (int i = 0; i < n; i++) tms[i] = seq[i];
  endtask

  function automatic logic [15:0] model_rsp(input logic [1:0] op, input int len,
                                            input logic [15:0] data, input bit loop,
                                            input logic [15:0] pat);
    int eff;
    logic [15:0] lenmask;
    eff = (len > 16) ? 16 : len;
    lenmask = (eff >= 16) ? 16'hFFFF : 16'((1 << eff) - 1);
    if (op >= 2) return 16'h0;
    return (loop ? data : pat) & lenmask;
  endfunction

  task automatic wait_ready(input string name);
    int t = 0;
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    chk({name, "_ready"}, cmd_ready, 1);
  endtask

  task automatic wait_rsp(input string name);
    int t = 0;
    while (!rsp_valid && t < 500) begin @(negedge clk); t++; end
    chk({name, "_rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input int len,
                         input logic [15:0] data, input bit loop, input logic [15:0] pat,
                         input int delay, input logic [15:0] exp_rsp, input int exp_periods);
    int base, n, cnt;
    logic [63:0] etms, etdi, emask, gtms, gtdi;
    logic [15:0] got;
    wait_ready(name);
    tdo_loop = loop; tdo_pat = pat; tdo_pre = (op == 1) ? 4 : 3;
    tdo_base = rise_cnt; base = rise_cnt;
    cmd_op = op; cmd_len = 5'(len); cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({name, "_ready_fall"}, cmd_ready, 0);
    wait_rsp(name);
    got = rsp_data;
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_rsp_drop"}, rsp_valid, 0);
    chk({name, "_ready_back"}, cmd_ready, 1);
    chk({name, "_rsp_data"}, got, exp_rsp);
    cnt = rise_cnt - base;
    chk({name, "_periods"}, cnt, exp_periods);
    build_exp(op, len, data, n, etms, etdi, emask);
    gtms = '0; gtdi = '0;
    for (int i = 0; i < cnt && i < 64; i++) begin
      gtms[i] = tms_all[base + i];
      gtdi[i] = tdi_all[base + i];
    end
    chk({name, "_tms_seq"}, gtms, etms);
    chk({name, "_tdi_seq"}, gtdi & emask, etdi);
    $display("txn %s op=%0d len=%0d data=%h rsp=%h periods=%0d", name, op, len, data, got, cnt);
  endtask

  task automatic check_init(input string name);
    int t, base, hb;
    bit saw;
    logic [63:0] g;
    base = rise_cnt; hb = hi_total; saw = 1'b0;
    @(negedge clk);
    chk({name, "_busy_up"}, busy, 1);
`ifdef JTAG_MASTER_TRST_EN
    chk({name, "_trst_first"}, TRST, 0);
`endif
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      saw |= rsp_valid;
      t++;
    end
    chk({name, "_ready"}, cmd_ready, 1);
    chk({name, "_busy_down"}, busy, 0);
    chk({name, "_periods"}, rise_cnt - base, 6);
    chk({name, "_tck_high_clks"}, hi_total - hb, 12);
    g = '0;
    for (int i = 0; i < rise_cnt - base && i < 64; i++) g[i] = tms_all[base + i];
    chk({name, "_tms_seq"}, g, 64'h1F);
    chk({name, "_no_rsp"}, saw, 0);
    chk({name, "_tms_idle"}, TMS, 0);
`ifdef JTAG_MASTER_TRST_EN
    chk({name, "_trst_high"}, TRST, 1);
`endif
    $display("txn %s periods=%0d", name, rise_cnt - base);
  endtask

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [15:0] data;
    bit          loop;
    logic [15:0] pat;
    logic [15:0] exp_rsp;
    int          exp_periods;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base, t;
    vecs[0] = '{2'd0,  8, 16'h00A5, 1'b1, 16'h0000, 16'h00A5, 13};
    vecs[1] = '{2'd1,  4, 16'h000B, 1'b0, 16'h0016, 16'h0006, 10};  // 1-bit bypass, captures 0
    vecs[2] = '{2'd0,  0, 16'hFFFF, 1'b1, 16'h0000, 16'h0000,  0};
    vecs[3] = '{2'd0, 20, 16'h1234, 1'b1, 16'h0000, 16'h1234, 21};
    vecs[4] = '{2'd2,  7, 16'h5555, 1'b1, 16'h0000, 16'h0000,  6};
    vecs[5] = '{2'd3,  3, 16'hAAAA, 1'b0, 16'hFFFF, 16'h0000,  6};
    vecs[6] = '{2'd1, 16, 16'hBEEF, 1'b1, 16'h0000, 16'hBEEF, 22};
    vecs[7] = '{2'd0,  1, 16'h0000, 1'b0, 16'h0001, 16'h0001,  6};
    vecs[8] = '{2'd1,  0, 16'h00FF, 1'b1, 16'h0000, 16'h0000,  0};
    vecs[9] = '{2'd0,  5, 16'h001F, 1'b0, 16'hFFEA, 16'h000A, 10};

    repeat (3) @(negedge clk);
    chk("rst_tck", TCK, 0);
    chk("rst_tms", TMS, 1);
    chk("rst_tdi", TDI, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
`ifdef JTAG_MASTER_TRST_EN
    chk("rst_trst", TRST, 0);
`endif
    nRST = 1'b1;
    check_init("init");

    for (int i = 0; i < 10; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].loop,
              vecs[i].pat, 0, vecs[i].exp_rsp, vecs[i].exp_periods);

    // Back-pressure: response held, next command waits for the handshake.
    wait_ready("bp");
    tdo_loop = 1'b1; tdo_pre = 3; tdo_base = rise_cnt;
    cmd_op = 2'd0; cmd_len = 5'd4; cmd_data = 16'h0009; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = 2'd1; cmd_len = 5'd3; cmd_data = 16'h0005;
    wait_rsp("bp");
    chk("bp_data", rsp_data, 16'h0009);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 16'h0009);
      chk("bp_no_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    base = rise_cnt; tdo_base = rise_cnt; tdo_pre = 4;
    chk("bp_ready_after", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_accept", busy, 1);
    wait_rsp("bp2");
    chk("bp2_data", rsp_data, 16'h0005);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp2_periods", rise_cnt - base, 9);
    $display("txn backpressure rsp1=0009 rsp2=0005");

    // nRST pulse in the middle of a 16-bit DR shift.
    wait_ready("rstp");
    tdo_loop = 1'b1; tdo_pre = 3; tdo_base = rise_cnt; base = rise_cnt;
    cmd_op = 2'd0; cmd_len = 5'd16; cmd_data = 16'hC3A5; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (rise_cnt - base < 8 && t < 300) begin @(negedge clk); t++; end
    chk("rstp_in_shift", (rise_cnt - base) >= 8, 1);
    nRST = 1'b0;
    #1;
    chk("rstp_tck", TCK, 0);
    chk("rstp_tms", TMS, 1);
    chk("rstp_tdi", TDI, 0);
    chk("rstp_cmd_ready", cmd_ready, 0);
    chk("rstp_rsp_valid", rsp_valid, 0);
    chk("rstp_rsp_data", rsp_data, 0);
    chk("rstp_busy", busy, 0);
`ifdef JTAG_MASTER_TRST_EN
    chk("rstp_trst", TRST, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    check_init("reinit");

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      int          len;
      logic [15:0] data, pat;
      bit          loop;
      int          n;
      logic [63:0] a, b, c;
      op   = 2'($urandom_range(0, 3));
      len  = $urandom_range(0, 20);
      data = 16'($urandom);
      pat  = 16'($urandom);
      loop = 1'($urandom_range(0, 1));
      build_exp(op, len, data, n, a, b, c);
      run_cmd($sformatf("rnd%0d", i), op, len, data, loop, pat, $urandom_range(0, 3),
              model_rsp(op, len, data, loop, pat), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
# jtag_master

JTAG host-side controller: it generates TCK/TMS/TDI from the system clock and samples TDO, so the team's TAP (`jtag` top) can be driven from on-chip logic or a bench without a hand-written TMS sequence. It accepts IR-scan, DR-scan and TAP-reset commands over a valid/ready handshake and returns the captured TDO bits over a valid/ready response channel. It sits between a command source (CPU bus bridge, debug FSM or testbench) and the JTAG pins of a TAP.

## Interface
- MAX_LEN, 16: maximum scan length in bits; width of cmd_data/rsp_data.
- CLK_DIV, 2: TCK half-period in clk cycles (≥1); one TCK period = 2*CLK_DIV clk.
- clk  in  1  system clock; one clock.
- nRST  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready on a clk edge.
- cmd_op  in  2  0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (treated as TAP reset).
- cmd_len  in  $clog2(MAX_LEN+1)  scan length in bits.
- cmd_data  in  MAX_LEN  TDI bits, bit 0 shifted first.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  MAX_LEN  captured TDO; bit i = TDO sampled in shift bit i; bits ≥ len are 0.
- busy  out  1  high whenever state ≠ IDLE.
- TCK, TMS, TDI  out  1  JTAG pins to the TAP.
- TDO  in  1  JTAG pin from the TAP.

## Operation
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0; state INIT.
- States: INIT → IDLE ↔ (PRE → SHIFT → POST) → RESP → IDLE; TLR for reset commands.
- INIT (busy=1 from the first clk after reset release): 5 TCK periods with TMS=1, then 1 with TMS=0. TAP ends in Run-Test/Idle. Go to IDLE.
- IDLE: cmd_ready=1 only here and only when rsp_valid=0. TCK held 0 and TMS held 0. On accept, latch op, len and data.
- Length rules:
  - Effective len = min(cmd_len, MAX_LEN).
  - len=0 scan: no TCK pulses; go straight to RESP with rsp_data=0.
- PRE TMS sequence: DR scan = 1,0,0 (Select-DR, Capture-DR, Shift-DR). IR scan = 1,1,0,0.
- SHIFT: len periods.
  - TDI = data[i].
  - TMS=0, except TMS=1 on the last bit (→Exit1).
  - TDO sampled every period into rsp_data[i].
- POST: TMS=1 (Update), then TMS=0 (Run-Test/Idle).
- TLR (op 2/3): 5 periods TMS=1, 1 period TMS=0; rsp_data=0, then RESP.
- RESP: rsp_valid=1 until rsp_ready, then IDLE. Every command, reset included, produces exactly one response.
- TCK periods per command: DR = len+5, IR = len+6, reset = 6.

## Timing
- Each TCK period = CLK_DIV clk low phase, then CLK_DIV clk high phase.
- TMS/TDI change only on the clk edge that drives TCK 0→… low, i.e. at the start of the low phase. They are stable through the rising edge.
- TDO is registered on the same clk edge that drives TCK 1. The TAP updates TDO on falling TCK, so the sampled value is the bit just shifted.
- First TCK low phase starts the clk after accept.
- rsp_valid rises the clk after the final TCK falling edge of POST (TCK left at 0).
- cmd_ready falls in the accept cycle; earliest back-to-back accept is the clk after the response handshake.
- nRST asserted mid-command: everything returns to reset values immediately and the command is dropped. After release, INIT re-synchronises the TAP.
- cmd_valid while busy is ignored (not accepted).
- rsp_ready held high: response completes in one cycle.

## Configuration
- JTAG_MASTER_TRST_EN defined: adds output `TRST` (active-low).
  - TRST=0 while nRST=0.
  - TRST=0 for the first TCK period of INIT and of every TLR sequence; 1 otherwise.
- JTAG_MASTER_TRST_EN undefined: no TRST port; TAP reset is by TMS only. All other behaviour is identical.

## Test plan
- Reset release with CLK_DIV=2: 24 clk of TCK toggling; TMS = 1,1,1,1,1,0 per period; busy falls and cmd_ready rises after the last period.
- DR scan, TDO looped to TDI, len=8, data=0xA5: TMS = 1,0,0, then 0×7, then 1,1,0; 13 TCK periods; rsp_data=0x00A5.
- IR scan against 1-bit bypass model (TCK flop, captures 0), len=4, data=0xB: 10 TCK periods; rsp_data=0x6.
- len=0 and len=20 (MAX_LEN=16): 0 → rsp immediate, 0 TCK pulses, data 0. 20 → exactly 16 shift periods.
- Back-pressure: rsp_ready=0 for 10 clk after rsp_valid; rsp_valid and rsp_data held; cmd_ready stays 0; a new cmd_valid is not accepted until the response handshake.
- nRST pulse during SHIFT of a 16-bit DR scan: outputs return to reset values within the pulse; INIT reruns; no response is issued for the dropped command. With JTAG_MASTER_TRST_EN, TRST is low during the pulse.
